riscv_v_uop_seq: RTL and testbench

- Parametrised vector decode-side micro-op sequencer.
- Takes one decoded vector instruction (register addresses plus vtype.vlmul) and expands it into LMUL register-group micro-ops, one per cycle, with incrementing vs1/vs2/vd.
- Sits between instruction decode and the vector register-file read stage.
- Generalises the single-register decode path to register groups, adding valid/ready backpressure, alignment checking and a flush path.

---
 rtl/riscv_v_uop_seq_if.sv | 33 +++
 rtl/riscv_v_uop_seq.sv | 232 +++++++++++++++++++++++
 tb/tb_riscv_v_uop_seq.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_v_uop_seq_if.sv
// Decode-to-read-stage handshake bundle for the vector micro-op sequencer.
// slave = sequencer view, master = decode/read-stage environment view.
interface riscv_v_uop_seq_if #(
  parameter int ADDR_W = 5,
  parameter int IDX_W  = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_vs1;
  logic [ADDR_W-1:0] in_vs2;
  logic [ADDR_W-1:0] in_vd;
  logic [2:0]        in_vlmul;
  logic              in_vs1_fixed;
  logic              in_vd_single;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_vs1;
  logic [ADDR_W-1:0] out_vs2;
  logic [ADDR_W-1:0] out_vd;
  logic [IDX_W-1:0]  out_idx;
  logic              out_first;
  logic              out_last;

  modport slave (
    input  in_valid, in_vs1, in_vs2, in_vd, in_vlmul, in_vs1_fixed, in_vd_single, out_ready,
    output in_ready, out_valid, out_vs1, out_vs2, out_vd, out_idx, out_first, out_last
  );

  modport master (
    output in_valid, in_vs1, in_vs2, in_vd, in_vlmul, in_vs1_fixed, in_vd_single, out_ready,
    input  in_ready, out_valid, out_vs1, out_vs2, out_vd, out_idx, out_first, out_last
  );
endinterface

// File: rtl/riscv_v_uop_seq.sv
// Vector micro-op sequencer: expands one decoded instruction into LMUL register-group micro-ops.
// Optional performance counters are enabled by defining RISCV_V_UOP_SEQ_PERF_EN.
module riscv_v_uop_seq #(
  parameter int NUM_VREGS = 32,
  parameter int ADDR_W    = $clog2(NUM_VREGS),
  parameter int MAX_LMUL  = 8,
  parameter int IDX_W     = (MAX_LMUL > 1) ? $clog2(MAX_LMUL) : 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_pipe,
  input  logic        stall,
  riscv_v_uop_seq_if.slave io,
  output logic        illegal,
  output logic [31:0] perf_uops,
  output logic [31:0] perf_instrs,
  output logic [31:0] perf_illegal
);

  localparam int AW_EXT = (ADDR_W > 4) ? ADDR_W : 4;

  typedef enum logic {ST_IDLE = 1'b0, ST_SEQ = 1'b1} state_t;

  function automatic logic [3:0] group_size(input logic [2:0] vlmul);
    logic [3:0] n;
    case (vlmul)
      3'b000:  n = 4'd1;
      3'b001:  n = 4'd2;
      3'b010:  n = 4'd4;
      3'b011:  n = 4'd8;
      default: n = 4'd1;
    endcase
    return n;
  endfunction

  function automatic logic is_aligned(input logic [AW_EXT-1:0] base, input logic [3:0] n);
    return (base & AW_EXT'(n - 4'd1)) == {AW_EXT{1'b0}};
  endfunction

  state_t            state_r, state_nxt;
  logic [IDX_W-1:0]  cnt_r, cnt_nxt;
  logic [IDX_W-1:0]  last_r, last_nxt;
  logic [ADDR_W-1:0] vs1_r, vs1_nxt, vs2_r, vs2_nxt, vd_r, vd_nxt;
  logic              fixed_r, fixed_nxt, single_r, single_nxt;
  logic              out_valid_r, out_valid_nxt;
  logic [ADDR_W-1:0] out_vs1_r, out_vs1_nxt, out_vs2_r, out_vs2_nxt, out_vd_r, out_vd_nxt;
  logic [IDX_W-1:0]  out_idx_r, out_idx_nxt;
  logic              out_first_r, out_first_nxt, out_last_r, out_last_nxt;
  logic              illegal_r, illegal_nxt;

  logic [3:0]        n_s;
  logic              reserved_s, too_big_s, misalign_s, bad_s;
  logic              in_ready_s, accept_s, hs_s;
  logic [ADDR_W-1:0] cnt_ext_s;

  assign n_s        = group_size(io.in_vlmul);
  assign reserved_s = (io.in_vlmul == 3'b100);
  assign too_big_s  = ({28'd0, n_s} > 32'(MAX_LMUL));
  // Fixed vs1 and single-register vd are not group operands, so they carry no alignment rule.
  assign misalign_s = !is_aligned(AW_EXT'(io.in_vs2), n_s)
                   || (!io.in_vs1_fixed && !is_aligned(AW_EXT'(io.in_vs1), n_s))
                   || (!io.in_vd_single && !is_aligned(AW_EXT'(io.in_vd), n_s));
  assign bad_s      = reserved_s || too_big_s || misalign_s;

  assign in_ready_s = !stall && (state_r == ST_IDLE) && (!out_valid_r || io.out_ready);
  assign accept_s   = io.in_valid && in_ready_s && !clear_pipe;
  assign hs_s       = out_valid_r && io.out_ready;
  assign cnt_ext_s  = ADDR_W'(cnt_r);

  assign io.in_ready  = in_ready_s;
  assign io.out_valid = out_valid_r;
  assign io.out_vs1   = out_vs1_r;
  assign io.out_vs2   = out_vs2_r;
  assign io.out_vd    = out_vd_r;
  assign io.out_idx   = out_idx_r;
  assign io.out_first = out_first_r;
  assign io.out_last  = out_last_r;
  assign illegal      = illegal_r;

  // Next-state and next-micro-op selection: flush, then stall, then accept/sequence.
  always_comb begin
    state_nxt     = state_r;
    cnt_nxt       = cnt_r;
    last_nxt      = last_r;
    vs1_nxt       = vs1_r;
    vs2_nxt       = vs2_r;
    vd_nxt        = vd_r;
    fixed_nxt     = fixed_r;
    single_nxt    = single_r;
    out_valid_nxt = out_valid_r;
    out_vs1_nxt   = out_vs1_r;
    out_vs2_nxt   = out_vs2_r;
    out_vd_nxt    = out_vd_r;
    out_idx_nxt   = out_idx_r;
    out_first_nxt = out_first_r;
    out_last_nxt  = out_last_r;
    illegal_nxt   = 1'b0;
    if (clear_pipe) begin
      state_nxt     = ST_IDLE;
      cnt_nxt       = {IDX_W{1'b0}};
      out_valid_nxt = 1'b0;
    end else if (stall) begin
      illegal_nxt = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            if (bad_s) begin
              illegal_nxt   = 1'b1;
              out_valid_nxt = 1'b0;
            end else begin
              out_valid_nxt = 1'b1;
              out_vs1_nxt   = io.in_vs1;
              out_vs2_nxt   = io.in_vs2;
              out_vd_nxt    = io.in_vd;
              out_idx_nxt   = {IDX_W{1'b0}};
              out_first_nxt = 1'b1;
              out_last_nxt  = (n_s == 4'd1);
              vs1_nxt       = io.in_vs1;
              vs2_nxt       = io.in_vs2;
              vd_nxt        = io.in_vd;
              fixed_nxt     = io.in_vs1_fixed;
              single_nxt    = io.in_vd_single;
              last_nxt      = IDX_W'(n_s - 4'd1);
              if (n_s != 4'd1) begin
                state_nxt = ST_SEQ;
                cnt_nxt   = IDX_W'(1);
              end else begin
                state_nxt = ST_IDLE;
                cnt_nxt   = {IDX_W{1'b0}};
              end
            end
          end else if (hs_s) begin
            out_valid_nxt = 1'b0;
          end else begin
            out_valid_nxt = out_valid_r;
          end
        end
        ST_SEQ: begin
          if (hs_s) begin
            out_valid_nxt = 1'b1;
            out_vs1_nxt   = vs1_r + (fixed_r ? {ADDR_W{1'b0}} : cnt_ext_s);
            out_vs2_nxt   = vs2_r + cnt_ext_s;
            out_vd_nxt    = vd_r + (single_r ? {ADDR_W{1'b0}} : cnt_ext_s);
            out_idx_nxt   = cnt_r;
            out_first_nxt = 1'b0;
            out_last_nxt  = (cnt_r == last_r);
            if (cnt_r == last_r) begin
              state_nxt = ST_IDLE;
              cnt_nxt   = {IDX_W{1'b0}};
            end else begin
              state_nxt = ST_SEQ;
              cnt_nxt   = cnt_r + IDX_W'(1);
            end
          end else begin
            state_nxt = ST_SEQ;
          end
        end
        default: begin
          state_nxt     = ST_IDLE;
          cnt_nxt       = {IDX_W{1'b0}};
          out_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  // State, latched instruction and registered micro-op outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {IDX_W{1'b0}};
      last_r      <= {IDX_W{1'b0}};
      vs1_r       <= {ADDR_W{1'b0}};
      vs2_r       <= {ADDR_W{1'b0}};
      vd_r        <= {ADDR_W{1'b0}};
      fixed_r     <= 1'b0;
      single_r    <= 1'b0;
      out_valid_r <= 1'b0;
      out_vs1_r   <= {ADDR_W{1'b0}};
      out_vs2_r   <= {ADDR_W{1'b0}};
      out_vd_r    <= {ADDR_W{1'b0}};
      out_idx_r   <= {IDX_W{1'b0}};
      out_first_r <= 1'b0;
      out_last_r  <= 1'b0;
      illegal_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      cnt_r       <= cnt_nxt;
      last_r      <= last_nxt;
      vs1_r       <= vs1_nxt;
      vs2_r       <= vs2_nxt;
      vd_r        <= vd_nxt;
      fixed_r     <= fixed_nxt;
      single_r    <= single_nxt;
      out_valid_r <= out_valid_nxt;
      out_vs1_r   <= out_vs1_nxt;
      out_vs2_r   <= out_vs2_nxt;
      out_vd_r    <= out_vd_nxt;
      out_idx_r   <= out_idx_nxt;
      out_first_r <= out_first_nxt;
      out_last_r  <= out_last_nxt;
      illegal_r   <= illegal_nxt;
    end
  end

`ifdef RISCV_V_UOP_SEQ_PERF_EN
  logic [31:0] perf_uops_r, perf_instrs_r, perf_illegal_r;

  // Event counters survive flushes; illegal is counted at the accept that raises the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_uops_r    <= 32'd0;
      perf_instrs_r  <= 32'd0;
      perf_illegal_r <= 32'd0;
    end else if (!stall) begin
      if (hs_s) perf_uops_r <= perf_uops_r + 32'd1;
      if (accept_s && !bad_s) perf_instrs_r <= perf_instrs_r + 32'd1;
      if (accept_s && bad_s) perf_illegal_r <= perf_illegal_r + 32'd1;
    end
  end

  assign perf_uops    = perf_uops_r;
  assign perf_instrs  = perf_instrs_r;
  assign perf_illegal = perf_illegal_r;
`else
  assign perf_uops    = 32'd0;
  assign perf_instrs  = 32'd0;
  assign perf_illegal = 32'd0;
`endif

endmodule

// File: tb/tb_riscv_v_uop_seq.sv
// Table-driven, scoreboard-checked bench for riscv_v_uop_seq (default and MAX_LMUL=4 instances).
module tb_riscv_v_uop_seq;

  typedef struct {
    logic [2:0] vlmul;
    logic [4:0] vs1, vs2, vd;
    logic       fixed, single;
    int         exp_n;           // 0 means the instruction must be rejected
  } vec_t;

  typedef struct {
    logic [31:0] pack;
    logic        ill;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, clear_pipe = 1'b0, stall = 1'b0;
  logic illegal, illegal4;
  logic [31:0] perf_uops, perf_instrs, perf_illegal;
  logic [31:0] p4_uops, p4_instrs, p4_illegal;
  int n_tests = 0, n_fail = 0;
  bit rand_rdy = 1'b0;
  exp_t sb[$];
  vec_t tbl[13];

  riscv_v_uop_seq_if #(.ADDR_W(5), .IDX_W(3)) bus ();
  riscv_v_uop_seq_if #(.ADDR_W(5), .IDX_W(2)) bus4 ();

  riscv_v_uop_seq #(.NUM_VREGS(32), .MAX_LMUL(8)) dut (
    .clk(clk), .rst(rst), .clear_pipe(clear_pipe), .stall(stall), .io(bus.slave),
    .illegal(illegal), .perf_uops(perf_uops), .perf_instrs(perf_instrs), .perf_illegal(perf_illegal)
  );

  riscv_v_uop_seq #(.NUM_VREGS(32), .MAX_LMUL(4)) dut4 (
    .clk(clk), .rst(rst), .clear_pipe(1'b0), .stall(1'b0), .io(bus4.slave),
    .illegal(illegal4), .perf_uops(p4_uops), .perf_instrs(p4_instrs), .perf_illegal(p4_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pack_uop(input logic [4:0] vs1, input logic [4:0] vs2,
                                            input logic [4:0] vd, input logic [2:0] idx,
                                            input logic first, input logic last);
    return {12'd0, vs1, vs2, vd, idx, first, last};
  endfunction

  task automatic push_vec(input vec_t v);
    exp_t e;
    if (v.exp_n == 0) begin
      e.ill = 1'b1; e.pack = 32'd0;
      sb.push_back(e);
    end else begin
      for (int i = 0; i < v.exp_n; i++) begin
        e.ill  = 1'b0;
        e.pack = pack_uop(v.vs1 + (v.fixed ? 5'd0 : 5'(i)), v.vs2 + 5'(i),
                          v.vd + (v.single ? 5'd0 : 5'(i)), 3'(i),
                          i == 0, i == v.exp_n - 1);
        sb.push_back(e);
      end
    end
  endtask

  // Scoreboard monitor plus hold-stability check while backpressured.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_pack = 32'd0;
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] cur;
    cur = pack_uop(bus.out_vs1, bus.out_vs2, bus.out_vd, bus.out_idx, bus.out_first, bus.out_last)
          | {11'd0, bus.out_valid, 20'd0};
    if (!rst && (illegal || (bus.out_valid && bus.out_ready && !stall && !clear_pipe))) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {illegal, bus.out_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        if (e.ill) chk("illegal_pulse", {30'd0, illegal, bus.out_valid}, 32'd2);
        else       chk("uop", cur & 32'h000F_FFFF, e.pack);
      end
    end
    if (prev_hold && !rst) chk("hold_stable", cur, prev_pack);
    prev_hold = bus.out_valid && !bus.out_ready && !clear_pipe && !rst;
    prev_pack = cur;
  end

  always begin
    @(posedge clk); #1;
    if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input vec_t v);
    bit done = 1'b0;
    bus.in_valid = 1'b1; bus.in_vlmul = v.vlmul;
    bus.in_vs1 = v.vs1; bus.in_vs2 = v.vs2; bus.in_vd = v.vd;
    bus.in_vs1_fixed = v.fixed; bus.in_vd_single = v.single;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready && !clear_pipe) begin
        done = 1'b1;
        push_vec(v);
      end
      step();
    end
    bus.in_valid = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.out_valid && !illegal) done = 1'b1;
      step();
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{3'b010, 5'd4,  5'd8,  5'd12, 1'b0, 1'b0, 4};
    tbl[1]  = '{3'b001, 5'd0,  5'd2,  5'd13, 1'b0, 1'b0, 0};
    tbl[2]  = '{3'b100, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 0};
    tbl[3]  = '{3'b001, 5'd4,  5'd2,  5'd13, 1'b0, 1'b1, 2};
    tbl[4]  = '{3'b111, 5'd3,  5'd5,  5'd7,  1'b0, 1'b0, 1};
    tbl[5]  = '{3'b011, 5'd8,  5'd16, 5'd24, 1'b0, 1'b0, 8};
    tbl[6]  = '{3'b011, 5'd3,  5'd0,  5'd8,  1'b1, 1'b0, 8};
    tbl[7]  = '{3'b000, 5'd31, 5'd31, 5'd31, 1'b0, 1'b0, 1};
    tbl[8]  = '{3'b010, 5'd0,  5'd6,  5'd0,  1'b0, 1'b0, 0};
    tbl[9]  = '{3'b010, 5'd2,  5'd0,  5'd0,  1'b0, 1'b0, 0};
    tbl[10] = '{3'b101, 5'd9,  5'd10, 5'd11, 1'b0, 1'b0, 1};
    tbl[11] = '{3'b110, 5'd1,  5'd2,  5'd3,  1'b0, 1'b0, 1};
    tbl[12] = '{3'b011, 5'd4,  5'd8,  5'd24, 1'b0, 1'b0, 0};

    bus.in_valid = 1'b0; bus.in_vlmul = 3'b000; bus.in_vs1 = 5'd0; bus.in_vs2 = 5'd0;
    bus.in_vd = 5'd0; bus.in_vs1_fixed = 1'b0; bus.in_vd_single = 1'b0; bus.out_ready = 1'b1;
    bus4.in_valid = 1'b0; bus4.in_vlmul = 3'b000; bus4.in_vs1 = 5'd0; bus4.in_vs2 = 5'd0;
    bus4.in_vd = 5'd0; bus4.in_vs1_fixed = 1'b0; bus4.in_vd_single = 1'b0; bus4.out_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    @(negedge clk);
    chk("reset_state", {28'd0, bus.out_valid, illegal, bus.in_ready, bus.out_first}, 32'h2);
    chk("reset_perf", perf_uops | perf_instrs | perf_illegal, 32'd0);
    step();

    // Performance counters: LMUL=4, LMUL=1, one illegal.
    send(tbl[0]); send(tbl[4]); send(tbl[1]); drain();
`ifdef RISCV_V_UOP_SEQ_PERF_EN
    chk("perf_uops", perf_uops, 32'd5);
    chk("perf_instrs", perf_instrs, 32'd2);
    chk("perf_illegal", perf_illegal, 32'd1);
`else
    chk("perf_uops", perf_uops, 32'd0);
    chk("perf_instrs", perf_instrs, 32'd0);
    chk("perf_illegal", perf_illegal, 32'd0);
`endif

    for (int i = 0; i < 13; i++) send(tbl[i]);
    drain();
    rand_rdy = 1'b1;
    for (int i = 0; i < 13; i++) send(tbl[i]);
    rand_rdy = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    // in_ready low while the group is being expanded.
    send(tbl[0]);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); chk("in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
      step();
    end
    drain();

    // Backpressure on cycles +2 and +3 holds idx1.
    send(tbl[0]);
    step(); bus.out_ready = 1'b0;
    step();
    @(negedge clk); chk("held_idx", {29'd0, bus.out_idx}, 32'd1);
    step(); bus.out_ready = 1'b1;
    drain();

    // Illegal pulse lasts one cycle.
    send(tbl[1]);
    step();
    @(negedge clk); chk("illegal_drop", {30'd0, illegal, bus.out_valid}, 32'd0);
    step();

    // Flush on cycle +2 of an LMUL=8 sequence, then a new LMUL=1 instruction.
    send('{3'b011, 5'd0, 5'd8, 5'd16, 1'b0, 1'b0, 8});
    step(); clear_pipe = 1'b1;
    step(); clear_pipe = 1'b0; sb.delete();
    @(negedge clk);
    chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    send(tbl[7]); drain();

    // Stall mid-sequence, and an illegal pulse dropping under stall.
    send(tbl[0]);
    stall = 1'b1;
    @(negedge clk); chk("stall_ready", {31'd0, bus.in_ready}, 32'd0);
    step(); step();
    stall = 1'b0;
    drain();
    send(tbl[2]);
    stall = 1'b1;
    step();
    @(negedge clk); chk("stall_illegal_drop", {31'd0, illegal}, 32'd0);
    step();
    stall = 1'b0;
    drain();

    // MAX_LMUL=4 instance: LMUL=8 is illegal, LMUL=4 is accepted.
    bus4.in_vlmul = 3'b011; bus4.in_valid = 1'b1;
    step(); bus4.in_valid = 1'b0;
    @(negedge clk); chk("max4_lmul8", {30'd0, illegal4, bus4.out_valid}, 32'd2);
    step();
    bus4.in_vlmul = 3'b010; bus4.in_valid = 1'b1;
    step(); bus4.in_valid = 1'b0;
    @(negedge clk);
    chk("max4_lmul4", {29'd0, illegal4, bus4.out_valid, bus4.out_last}, 32'd2);
    repeat (6) step();

    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
